// File: rtl/id_field_stage.sv
// -----------------------------------------------------------------------------
// id_field_stage
//
// Decode-side pipeline stage sitting directly upstream of the immediate
// extender. Each accepted instruction is registered together with its PC and
// the 2-bit extend-control code decoded from the opcode. The registered word is
// then split into its MIPS fields by plain wiring.
//
// The stage holds at most two entries: the presented (output) entry and one
// skid entry. It uses valid/ready handshakes on both sides and keeps strict
// FIFO order. A synchronous flush drops every held entry for a branch/jump
// redirect.
//
// Optional feature macro: DECODE_ILLEGAL_EN
//   When it is defined, out_illegal flags any opcode outside the decoded set.
//   The flag is registered with its entry.
//   When it is undefined, out_illegal is tied to 0.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-low
//   flush        discard all held entries at this edge (wins over accepts)
//   in_valid     upstream instruction valid
//   in_ready     stage can accept (skid entry empty)
//   in_instr     instruction word
//   in_pc        PC of in_instr
//   out_valid    presented entry valid
//   out_ready    downstream accepts the presented entry
//   out_pc       PC of the presented entry
//   out_op       instr[31:26]
//   out_rs       instr[25:21]
//   out_rt       instr[20:16]
//   out_rd       instr[15:11]
//   out_shamt    instr[10:6]
//   out_funct    instr[5:0]
//   out_im       instr[15:0], extender immediate input
//   out_ext      extend code: 01 sign, 00 zero, 10 upper, 11 zero word
//   out_jaddr    instr[25:0]
//   out_illegal  unknown opcode (DECODE_ILLEGAL_EN only)
// -----------------------------------------------------------------------------
module id_field_stage #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [5:0]         out_op,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_shamt,
  output logic [5:0]         out_funct,
  output logic [15:0]        out_im,
  output logic [1:0]         out_ext,
  output logic [25:0]        out_jaddr,
  output logic               out_illegal
);

  function automatic logic [1:0] ext_code(input logic [5:0] op);
    logic [1:0] code;
    case (op)
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h04, 6'h05, 6'h23, 6'h2B: code = 2'b01;
      6'h0C, 6'h0D, 6'h0E:        code = 2'b00;
      6'h0F:                      code = 2'b10;
      default:                    code = 2'b11;
    endcase
    return code;
  endfunction

  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [PC_W-1:0]    out_pc_q,    out_pc_d;
  logic [1:0]         out_ext_q,   out_ext_d;

  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
  logic [1:0]         skid_ext_q,   skid_ext_d;

  logic       out_take;
  logic       ld_out_skid;
  logic       ld_out_in;
  logic       ld_skid;
  logic [1:0] in_ext;

  assign in_ready = ~skid_valid_q;
  assign in_ext   = ext_code(in_instr[31:26]);

  // The output register frees up when it is empty or being consumed. A full
  // skid always drains first; in_ready is low then, so no input can compete.
  assign out_take    = ~out_valid_q | out_ready;
  assign ld_out_skid = ~flush & out_take & skid_valid_q;
  assign ld_out_in   = ~flush & out_take & ~skid_valid_q & in_valid;
  assign ld_skid     = ~flush & ~out_take & ~skid_valid_q & in_valid;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_take) begin
      out_valid_d  = skid_valid_q | in_valid;
      skid_valid_d = 1'b0;
    end else if (ld_skid) begin
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_ext_d    = out_ext_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_ext_d   = skid_ext_q;
    if (ld_out_skid) begin
      out_instr_d = skid_instr_q;
      out_pc_d    = skid_pc_q;
      out_ext_d   = skid_ext_q;
    end else if (ld_out_in) begin
      out_instr_d = in_instr;
      out_pc_d    = in_pc;
      out_ext_d   = in_ext;
    end
    if (ld_skid) begin
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
      skid_ext_d   = in_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_ext_q    <= 2'b00;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_ext_q   <= 2'b00;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_ext_q    <= out_ext_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_ext_q   <= skid_ext_d;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  function automatic logic is_illegal(input logic [5:0] op);
    logic ill;
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h23, 6'h2B: ill = 1'b0;
      default:      ill = 1'b1;
    endcase
    return ill;
  endfunction

  logic out_ill_q, out_ill_d;
  logic skid_ill_q, skid_ill_d;

  always_comb begin
    out_ill_d  = out_ill_q;
    skid_ill_d = skid_ill_q;
    if (ld_out_skid) begin
      out_ill_d = skid_ill_q;
    end else if (ld_out_in) begin
      out_ill_d = is_illegal(in_instr[31:26]);
    end
    if (ld_skid) begin
      skid_ill_d = is_illegal(in_instr[31:26]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_ill_q  <= 1'b0;
      skid_ill_q <= 1'b0;
    end else begin
      out_ill_q  <= out_ill_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  assign out_illegal = out_ill_q;
`else
  assign out_illegal = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_ext   = out_ext_q;
  assign out_op    = out_instr_q[31:26];
  assign out_rs    = out_instr_q[25:21];
  assign out_rt    = out_instr_q[20:16];
  assign out_rd    = out_instr_q[15:11];
  assign out_shamt = out_instr_q[10:6];
  assign out_funct = out_instr_q[5:0];
  assign out_im    = out_instr_q[15:0];
  assign out_jaddr = out_instr_q[25:0];

endmodule

// File: tb/tb_id_field_stage.sv
module tb_id_field_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_op;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_im;
  logic [1:0]  out_ext;
  logic [25:0] out_jaddr;
  logic        out_illegal;

  always #5 clk = ~clk;

  id_field_stage #(.INSTR_W(32), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_im(out_im),
    .out_ext(out_ext), .out_jaddr(out_jaddr), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t q[$];
  bit     fields_zero;
  int     checks = 0;
  int     errors = 0;

  function automatic logic [1:0] ref_ext(input int op);
    if (op inside {'h08, 'h09, 'h0A, 'h0B, 'h04, 'h05, 'h23, 'h2B}) return 2'b01;
    if (op inside {'h0C, 'h0D, 'h0E}) return 2'b00;
    if (op == 'h0F) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic ref_illegal(input int op);
`ifdef DECODE_ILLEGAL_EN
    return !(op inside {'h00, 'h02, 'h03, 'h04, 'h05, 'h08, 'h09, 'h0A, 'h0B,
                        'h0C, 'h0D, 'h0E, 'h0F, 'h23, 'h2B});
`else
    return (op < 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      int unsigned w;
      w = q[0].instr;
      chk("out_pc", 64'(out_pc), 64'(q[0].pc));
      chk("out_op", 64'(out_op), 64'(w / 67108864));
      chk("out_rs", 64'(out_rs), 64'((w / 2097152) % 32));
      chk("out_rt", 64'(out_rt), 64'((w / 65536) % 32));
      chk("out_rd", 64'(out_rd), 64'((w / 2048) % 32));
      chk("out_shamt", 64'(out_shamt), 64'((w / 64) % 32));
      chk("out_funct", 64'(out_funct), 64'(w % 64));
      chk("out_im", 64'(out_im), 64'(w % 65536));
      chk("out_jaddr", 64'(out_jaddr), 64'(w % 67108864));
      chk("out_ext", 64'(out_ext), 64'(ref_ext(int'(w / 67108864))));
      chk("out_illegal", 64'(out_illegal), 64'(ref_illegal(int'(w / 67108864))));
    end else if (fields_zero) begin
      chk("rst_fields", {out_pc, out_op, out_rs, out_rt, out_illegal},
          64'd0);
      chk("rst_fields2", {out_rd, out_shamt, out_funct, out_im, out_ext, out_jaddr[0]},
          64'd0);
    end
  endtask

  // One clock: drive, update the model at the edge, check at the falling edge.
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic rdy, input logic fl, input logic rstn);
    int pre;
    in_valid = v; in_instr = instr; in_pc = pc;
    out_ready = rdy; flush = fl; rst_n = rstn;
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      fields_zero = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      pre = q.size();
      if (pre > 0 && rdy) void'(q.pop_front());
      if (v && pre < 2) begin
        q.push_back('{instr: instr, pc: pc});
        fields_zero = 1'b0;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  ops [16];
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    w = $urandom;
    if ($urandom_range(0, 3) != 0) w[31:26] = ops[$urandom_range(0, 15)];
    return w;
  endfunction

  initial begin
    logic [31:0] pc;
    fields_zero = 1'b1;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;

    step(0, 32'h0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 1);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // addi
    step(1, 32'h2008FFFC, 32'h40, 1, 0, 1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_ext", 64'(out_ext), 64'd1);
    chk("t1_im", 64'(out_im), 64'hFFFC);
    chk("t1_rt", 64'(out_rt), 64'd8);

    // lui then ori
    step(1, 32'h3C011234, 32'h44, 1, 0, 1);
    chk("t2_lui_ext", 64'(out_ext), 64'd2);
    chk("t2_lui_im", 64'(out_im), 64'h1234);
    step(1, 32'h3421ABCD, 32'h48, 1, 0, 1);
    chk("t2_ori_ext", 64'(out_ext), 64'd0);
    chk("t2_ori_im", 64'(out_im), 64'hABCD);
    step(0, 32'h0, 32'h0, 1, 0, 1);

    // stall, skid fill, release
    step(1, 32'h8C220004, 32'h50, 0, 0, 1);
    step(1, 32'hAC230008, 32'h54, 0, 0, 1);
    chk("t3_skid_full", 64'(in_ready), 64'd0);
    step(1, 32'h2024000C, 32'h58, 0, 0, 1);
    chk("t3_held_pc", 64'(out_pc), 64'h50);
    step(1, 32'h2024000C, 32'h58, 1, 0, 1);
    chk("t3_second_pc", 64'(out_pc), 64'h54);
    step(1, 32'h2024000C, 32'h58, 1, 0, 1);
    chk("t3_third_pc", 64'(out_pc), 64'h58);
    step(0, 32'h0, 32'h0, 1, 0, 1);

    // flush with skid full and a pending input
    step(1, 32'h10220003, 32'h60, 0, 0, 1);
    step(1, 32'h14220003, 32'h64, 0, 0, 1);
    step(1, 32'h08000010, 32'h68, 0, 1, 1);
    chk("t4_flush_valid", 64'(out_valid), 64'd0);
    chk("t4_flush_ready", 64'(in_ready), 64'd1);
    step(0, 32'h0, 32'h0, 1, 0, 1);

    // reset mid-stall with both entries held
    step(1, 32'h3001FFFF, 32'h70, 0, 0, 1);
    step(1, 32'h3802AAAA, 32'h74, 0, 0, 1);
    step(0, 32'h0, 32'h0, 0, 0, 0);
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_im", 64'(out_im), 64'd0);
    chk("t5_rst_ready", 64'(in_ready), 64'd1);

    // unknown opcode 3F
    step(1, 32'hFC000000, 32'h80, 1, 0, 1);
    chk("t6_ext", 64'(out_ext), 64'd3);
`ifdef DECODE_ILLEGAL_EN
    chk("t6_illegal", 64'(out_illegal), 64'd1);
`else
    chk("t6_illegal", 64'(out_illegal), 64'd0);
`endif
    step(0, 32'h0, 32'h0, 1, 0, 1);

    // randomized traffic
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), pc,
           $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 79) != 0);
      pc = pc + 4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
